// File: rtl/lamp_conflict_monitor.sv
// lamp_conflict_monitor
//   Safety stage between the two-direction traffic-light controller and the
//   physical lamp drivers. Lamp commands are registered and passed through
//   with one cycle of latency. Each sample is checked for illegal lamp
//   combinations, which must persist for FILT samples, and for short yellow
//   phases, which fault at once. A fault latches a code and forces both
//   directions to flashing red until it is acknowledged on a clean sample.
//
//   Optional feature macro: LAMP_MON_YDWELL_EN
//     defined   -> yellow-dwell counters present, fault codes 6/7 possible
//     undefined -> no yellow-dwell checking, MIN_YLW unused
//
//   Ports:
//     CK                   clock, rising edge
//     CLRN                 synchronous active-low reset
//     GRN1/YLW1/RED1       direction-1 lamp commands from the controller
//     GRN2/YLW2/RED2       direction-2 lamp commands from the controller
//     ACK                  operator acknowledge
//     L_GRN1..L_RED2       registered lamp drives
//     FAULT                high while in the fault state
//     FCODE[2:0]           latched fault code, 0 = none
//     FLASH                flash phase, meaningful only while FAULT is high

module lamp_conflict_monitor #(
  parameter int FILT      = 2,
  parameter int MIN_YLW   = 3,
  parameter int FLASH_DIV = 8
) (
  input  logic       CK,
  input  logic       CLRN,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       ACK,
  output logic       L_GRN1,
  output logic       L_YLW1,
  output logic       L_RED1,
  output logic       L_GRN2,
  output logic       L_YLW2,
  output logic       L_RED2,
  output logic       FAULT,
  output logic [2:0] FCODE,
  output logic       FLASH
);

  // Elaboration-time guard on the legal parameter ranges.
  if (FILT < 1 || FILT > 15 || MIN_YLW < 1 || MIN_YLW > 15 ||
      FLASH_DIV < 1 || FLASH_DIV > 255) begin : g_bad_params
    $error("lamp_conflict_monitor: parameter out of range");
  end

  typedef enum logic [1:0] {S_INIT, S_MON, S_PEND, S_FLT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic        flash_q, flash_d;
  logic [2:0]  fcode_q, fcode_d;
  logic [5:0]  lamps_q, lamps_d;

  logic [5:0]  lampsIn;
  logic [1:0]  dir1Cnt, dir2Cnt;
  logic [2:0]  staticCode;
  logic        staticConf;
  logic        shortY1, shortY2, shortAny;
  logic [2:0]  entryCode;
  logic        exitAck;

  assign lampsIn = {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
  assign dir1Cnt = 2'(GRN1) + 2'(YLW1) + 2'(RED1);
  assign dir2Cnt = 2'(GRN2) + 2'(YLW2) + 2'(RED2);

  // Static conflict code, lowest code has priority.
  always_comb begin
    staticCode = 3'd0;
    if (GRN1 && GRN2)        staticCode = 3'd1;
    else if (dir1Cnt > 2'd1) staticCode = 3'd2;
    else if (dir2Cnt > 2'd1) staticCode = 3'd3;
    else if (dir1Cnt == 2'd0) staticCode = 3'd4;
    else if (dir2Cnt == 2'd0) staticCode = 3'd5;
  end

  assign staticConf = (staticCode != 3'd0);
  assign exitAck    = (state_q == S_FLT) && ACK && !staticConf;

`ifdef LAMP_MON_YDWELL_EN
  logic [3:0] y1Cnt_q, y1Cnt_d, y2Cnt_q, y2Cnt_d;

  // A nonzero counter means the previous sample had yellow high.
  assign shortY1 = !YLW1 && (y1Cnt_q != 4'd0) && (y1Cnt_q < 4'(MIN_YLW));
  assign shortY2 = !YLW2 && (y2Cnt_q != 4'd0) && (y2Cnt_q < 4'(MIN_YLW));

  // Counters are idle in INIT and cleared when a fault is acknowledged.
  always_comb begin
    y1Cnt_d = 4'd0;
    y2Cnt_d = 4'd0;
    if (state_q != S_INIT && !exitAck) begin
      if (YLW1) y1Cnt_d = (y1Cnt_q == 4'(MIN_YLW)) ? y1Cnt_q : y1Cnt_q + 4'd1;
      if (YLW2) y2Cnt_d = (y2Cnt_q == 4'(MIN_YLW)) ? y2Cnt_q : y2Cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CK) begin
    if (!CLRN) begin
      y1Cnt_q <= 4'd0;
      y2Cnt_q <= 4'd0;
    end else begin
      y1Cnt_q <= y1Cnt_d;
      y2Cnt_q <= y2Cnt_d;
    end
  end
`else
  assign shortY1 = 1'b0;
  assign shortY2 = 1'b0;
`endif

  assign shortAny  = shortY1 || shortY2;
  // A coincident static conflict keeps its code even when the short yellow
  // is what forces immediate entry.
  assign entryCode = staticConf ? staticCode : (shortY1 ? 3'd6 : 3'd7);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    flash_d = flash_q;
    fcode_d = fcode_q;
    case (state_q)
      S_INIT: begin
        if (dir1Cnt == 2'd1 && dir2Cnt == 2'd1) state_d = S_MON;
      end
      S_MON: begin
        if (shortAny || (staticConf && FILT == 1)) begin
          state_d = S_FLT;
          fcode_d = entryCode;
          flash_d = 1'b1;
          div_d   = 8'd0;
          cnt_d   = 4'd0;
        end else if (staticConf) begin
          state_d = S_PEND;
          cnt_d   = 4'd1;
        end
      end
      S_PEND: begin
        if (shortAny || (staticConf && (cnt_q + 4'd1) >= 4'(FILT))) begin
          state_d = S_FLT;
          fcode_d = entryCode;
          flash_d = 1'b1;
          div_d   = 8'd0;
          cnt_d   = 4'd0;
        end else if (!staticConf) begin
          state_d = S_MON;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_FLT: begin
        if (exitAck) begin
          state_d = S_MON;
          fcode_d = 3'd0;
          flash_d = 1'b0;
          div_d   = 8'd0;
        end else if (div_q == 8'(FLASH_DIV - 1)) begin
          flash_d = !flash_q;
          div_d   = 8'd0;
        end else begin
          div_d   = div_q + 8'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
    // Forced lamps appear on the same edge that enters the fault state.
    lamps_d = (state_d == S_FLT) ? {2'b00, flash_d, 2'b00, flash_d} : lampsIn;
  end

  always_ff @(posedge CK) begin
    if (!CLRN) begin
      state_q <= S_INIT;
      cnt_q   <= 4'd0;
      div_q   <= 8'd0;
      flash_q <= 1'b0;
      fcode_q <= 3'd0;
      lamps_q <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      flash_q <= flash_d;
      fcode_q <= fcode_d;
      lamps_q <= lamps_d;
    end
  end

  assign {L_GRN1, L_YLW1, L_RED1, L_GRN2, L_YLW2, L_RED2} = lamps_q;
  assign FAULT = (state_q == S_FLT);
  assign FCODE = fcode_q;
  assign FLASH = flash_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// tb_lamp_conflict_monitor
//   Directed bench for lamp_conflict_monitor with default parameters
//   (FILT=2, MIN_YLW=3, FLASH_DIV=8). Yellow-dwell expectations follow
//   LAMP_MON_YDWELL_EN the same way the design does.

module tb_lamp_conflict_monitor;

  logic       CK = 1'b0;
  logic       CLRN;
  logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2, ACK;
  logic       L_GRN1, L_YLW1, L_RED1, L_GRN2, L_YLW2, L_RED2;
  logic       FAULT, FLASH;
  logic [2:0] FCODE;
  logic [5:0] lampsOut;

  int nCompared   = 0;
  int nMismatched = 0;

  lamp_conflict_monitor dut (
    .CK(CK), .CLRN(CLRN),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .ACK(ACK),
    .L_GRN1(L_GRN1), .L_YLW1(L_YLW1), .L_RED1(L_RED1),
    .L_GRN2(L_GRN2), .L_YLW2(L_YLW2), .L_RED2(L_RED2),
    .FAULT(FAULT), .FCODE(FCODE), .FLASH(FLASH)
  );

  always #5 CK = ~CK;

  assign lampsOut = {L_GRN1, L_YLW1, L_RED1, L_GRN2, L_YLW2, L_RED2};

  // Lamp vector order: {GRN1, YLW1, RED1, GRN2, YLW2, RED2}.
  task applyStimulus(input logic [5:0] lamps, input logic ack);
    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = lamps;
    ACK = ack;
  endtask

  task tick;
    @(posedge CK);
    #1;
  endtask

  task test_reset;
    CLRN = 1'b0;
    applyStimulus(6'b000000, 1'b0);
    tick;
    nCompared++;
    if (lampsOut !== 6'b000000) begin
      nMismatched++; $display("[TB] FAIL reset_lamps got %b want %b", lampsOut, 6'b000000);
    end
    nCompared++;
    if ({FAULT, FCODE, FLASH} !== 5'b0) begin
      nMismatched++; $display("[TB] FAIL reset_flags got %b want %b", {FAULT, FCODE, FLASH}, 5'b0);
    end
  endtask

  task test_pass_through;
    CLRN = 1'b1;
    applyStimulus(6'b100001, 1'b0);
    tick;
    nCompared++;
    if (lampsOut !== 6'b100001) begin
      nMismatched++; $display("[TB] FAIL pass_g1r2 got %b want %b", lampsOut, 6'b100001);
    end
    nCompared++;
    if (FAULT !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL pass_fault got %b want 0", FAULT);
    end
    applyStimulus(6'b001100, 1'b0);
    tick;
    nCompared++;
    if (lampsOut !== 6'b001100) begin
      nMismatched++; $display("[TB] FAIL pass_r1g2 got %b want %b", lampsOut, 6'b001100);
    end
    applyStimulus(6'b100001, 1'b0);
    tick;
  endtask

  task test_static_filter;
    // One conflicting sample only: filtered out.
    applyStimulus(6'b100100, 1'b0);
    tick;
    nCompared++;
    if (FAULT !== 1'b0 || lampsOut !== 6'b100100) begin
      nMismatched++; $display("[TB] FAIL filt_one got fault=%b l=%b want fault=0 l=100100", FAULT, lampsOut);
    end
    applyStimulus(6'b100001, 1'b0);
    tick;
    nCompared++;
    if (FAULT !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL filt_clear got %b want 0", FAULT);
    end
    // Two conflicting samples: fault on the second edge.
    applyStimulus(6'b100100, 1'b0);
    tick;
    nCompared++;
    if (FAULT !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL filt_first got %b want 0", FAULT);
    end
    tick;
    nCompared++;
    if (FAULT !== 1'b1 || FCODE !== 3'd1) begin
      nMismatched++; $display("[TB] FAIL filt_fault got fault=%b code=%0d want fault=1 code=1", FAULT, FCODE);
    end
    nCompared++;
    if (lampsOut !== 6'b001001 || FLASH !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL filt_forced got l=%b flash=%b want l=001001 flash=1", lampsOut, FLASH);
    end
  endtask

  task test_flash_ack;
    logic expFlash;
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(6'b100100, (i >= 10 && i <= 12));
      tick;
      expFlash = ((i / 8) % 2) == 0;
      nCompared++;
      if (FAULT !== 1'b1) begin
        nMismatched++; $display("[TB] FAIL flt_hold cycle %0d got %b want 1", i, FAULT);
      end
      nCompared++;
      if (FLASH !== expFlash || lampsOut !== {2'b00, expFlash, 2'b00, expFlash}) begin
        nMismatched++; $display("[TB] FAIL flash cycle %0d got flash=%b l=%b want flash=%b", i, FLASH, lampsOut, expFlash);
      end
    end
    // Conflict gone but no acknowledge yet.
    applyStimulus(6'b100001, 1'b0);
    tick;
    nCompared++;
    if (FAULT !== 1'b1 || FCODE !== 3'd1) begin
      nMismatched++; $display("[TB] FAIL flt_noack got fault=%b code=%0d want fault=1 code=1", FAULT, FCODE);
    end
    applyStimulus(6'b100001, 1'b1);
    tick;
    nCompared++;
    if ({FAULT, FCODE, FLASH} !== 5'b0) begin
      nMismatched++; $display("[TB] FAIL ack_exit got %b want %b", {FAULT, FCODE, FLASH}, 5'b0);
    end
    nCompared++;
    if (lampsOut !== 6'b100001) begin
      nMismatched++; $display("[TB] FAIL ack_lamps got %b want %b", lampsOut, 6'b100001);
    end
    applyStimulus(6'b100001, 1'b0);
    tick;
  endtask

  task test_yellow;
    logic       expFault;
    logic [2:0] expCode;
`ifdef LAMP_MON_YDWELL_EN
    expFault = 1'b1;
    expCode  = 3'd6;
`else
    expFault = 1'b0;
    expCode  = 3'd0;
`endif
    // Two yellow samples, then red: short yellow.
    applyStimulus(6'b010001, 1'b0);
    tick;
    tick;
    nCompared++;
    if (FAULT !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL ylw_during got %b want 0", FAULT);
    end
    applyStimulus(6'b001001, 1'b0);
    tick;
    nCompared++;
    if (FAULT !== expFault || FCODE !== expCode) begin
      nMismatched++; $display("[TB] FAIL ylw_short got fault=%b code=%0d want fault=%b code=%0d", FAULT, FCODE, expFault, expCode);
    end
    nCompared++;
    if (lampsOut !== 6'b001001) begin
      nMismatched++; $display("[TB] FAIL ylw_lamps got %b want %b", lampsOut, 6'b001001);
    end
    applyStimulus(6'b100001, 1'b1);
    tick;
    nCompared++;
    if (FAULT !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL ylw_ack got %b want 0", FAULT);
    end
    // Three yellow samples, then red: legal.
    applyStimulus(6'b010001, 1'b0);
    tick;
    tick;
    tick;
    applyStimulus(6'b001001, 1'b0);
    tick;
    nCompared++;
    if (FAULT !== 1'b0 || FCODE !== 3'd0) begin
      nMismatched++; $display("[TB] FAIL ylw_legal got fault=%b code=%0d want fault=0 code=0", FAULT, FCODE);
    end
  endtask

  task test_priority;
    // Direction 1 green+yellow (code 2), direction 2 dark (code 5).
    applyStimulus(6'b110000, 1'b0);
    tick;
    nCompared++;
    if (FAULT !== 1'b0 || lampsOut !== 6'b110000) begin
      nMismatched++; $display("[TB] FAIL prio_pend got fault=%b l=%b want fault=0 l=110000", FAULT, lampsOut);
    end
    tick;
    nCompared++;
    if (FAULT !== 1'b1 || FCODE !== 3'd2) begin
      nMismatched++; $display("[TB] FAIL prio_code got fault=%b code=%0d want fault=1 code=2", FAULT, FCODE);
    end
  endtask

  task test_reset_mid_fault;
    CLRN = 1'b0;
    tick;
    nCompared++;
    if (lampsOut !== 6'b000000 || {FAULT, FCODE, FLASH} !== 5'b0) begin
      nMismatched++; $display("[TB] FAIL midflt_reset got l=%b flags=%b want all 0", lampsOut, {FAULT, FCODE, FLASH});
    end
    CLRN = 1'b1;
    applyStimulus(6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      nCompared++;
      if (FAULT !== 1'b0 || lampsOut !== 6'b000000) begin
        nMismatched++; $display("[TB] FAIL init_dark cycle %0d got fault=%b l=%b want fault=0 l=000000", i, FAULT, lampsOut);
      end
    end
    applyStimulus(6'b100001, 1'b0);
    tick;
    nCompared++;
    if (FAULT !== 1'b0 || lampsOut !== 6'b100001) begin
      nMismatched++; $display("[TB] FAIL init_resume got fault=%b l=%b want fault=0 l=100001", FAULT, lampsOut);
    end
  endtask

  initial begin
    CLRN = 1'b0;
    applyStimulus(6'b000000, 1'b0);
    test_reset;
    test_pass_through;
    test_static_filter;
    test_flash_ack;
    test_yellow;
    test_priority;
    test_reset_mid_fault;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
